// File: rtl/argon_regfile_sequencer_if.sv
// ============================================================================
// Module      : argon_regfile_sequencer_if
// Description : Decode-side request and register-file bus signals of the
//               argon register-file sequencer, named from the sequencer's side.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface argon_regfile_sequencer_if #(
    parameter int DATA_W = 16,
    parameter int IDX_W  = 4
);
    logic              i_start;
    logic [IDX_W-1:0]  i_rd;
    logic [IDX_W-1:0]  i_rs1;
    logic [IDX_W-1:0]  i_rs2;
    logic [2:0]        i_op;
    logic [DATA_W-1:0] i_bus;
    logic [DATA_W-1:0] o_bus;
    logic              o_bus_drive;
    logic              o_selectLatch;
    logic              o_outputA;
    logic              o_outputB;
    logic              o_latchC;
    logic              o_busy;
    logic              o_done;
    logic [DATA_W-1:0] o_result;
    logic              o_zero;
    logic              o_carry;

    // Sequencer side
    modport slave (
        input  i_start, i_rd, i_rs1, i_rs2, i_op, i_bus,
        output o_bus, o_bus_drive, o_selectLatch, o_outputA, o_outputB,
               o_latchC, o_busy, o_done, o_result, o_zero, o_carry
    );

    // Decode / bus-environment side
    modport master (
        output i_start, i_rd, i_rs1, i_rs2, i_op, i_bus,
        input  o_bus, o_bus_drive, o_selectLatch, o_outputA, o_outputB,
               o_latchC, o_busy, o_done, o_result, o_zero, o_carry
    );
endinterface

`default_nettype wire

// File: rtl/argon_regfile_sequencer.sv
// ============================================================================
// Module      : argon_regfile_sequencer
// Description : Seven-state micro-sequencer running rd <- rs1 OP rs2 over the
//               register file's select/readA/readB/writeC bus protocol.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module argon_regfile_sequencer #(
    parameter int DATA_W = 16,
    parameter int IDX_W  = 4
) (
    input  wire logic                  i_Clk,
    input  wire logic                  i_Reset,
    argon_regfile_sequencer_if.slave   io_seq
);

    localparam int       c_SHW     = $clog2(DATA_W);
    localparam int       c_IDX_PAD = DATA_W - 3 * IDX_W;
    localparam logic [2:0] c_OP_ADD  = 3'd0;
    localparam logic [2:0] c_OP_SUB  = 3'd1;
    localparam logic [2:0] c_OP_AND  = 3'd2;
    localparam logic [2:0] c_OP_OR   = 3'd3;
    localparam logic [2:0] c_OP_XOR  = 3'd4;
    localparam logic [2:0] c_OP_SHL  = 3'd5;
    localparam logic [2:0] c_OP_SHR  = 3'd6;
    localparam logic [2:0] c_OP_PASS = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SEL  = 3'd1,
        S_RDA  = 3'd2,
        S_RDB  = 3'd3,
        S_CAPB = 3'd4,
        S_EXEC = 3'd5,
        S_WB   = 3'd6
    } state_t;

    state_t            r_state;
    state_t            w_next_state;

    logic [IDX_W-1:0]  r_rd;
    logic [IDX_W-1:0]  r_rs1;
    logic [IDX_W-1:0]  r_rs2;
    logic [2:0]        r_op;
    logic [DATA_W-1:0] r_opA;
    logic [DATA_W-1:0] r_opB;
    logic [DATA_W-1:0] r_result;
    logic              r_zero;
    logic              r_carry;
    logic              r_done;

    logic              w_sel;
    logic              w_outA;
    logic              w_outB;
    logic              w_latchC;
    logic              w_drive;
    logic [DATA_W-1:0] w_bus;
    logic [DATA_W-1:0] w_idx_word;

    logic [DATA_W:0]   w_sum;
    logic [DATA_W-1:0] w_alu_res;
    logic              w_alu_carry;

    assign w_idx_word = {{c_IDX_PAD{1'b0}}, r_rd, r_rs2, r_rs1};

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next state and Moore-decoded bus strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_sel        = 1'b0;
        w_outA       = 1'b0;
        w_outB       = 1'b0;
        w_latchC     = 1'b0;
        w_drive      = 1'b0;
        w_bus        = '0;
        case (r_state)
            S_IDLE: begin
                if (io_seq.i_start) begin
                    w_next_state = S_SEL;
                end
            end
            S_SEL: begin
                w_sel        = 1'b1;
                w_drive      = 1'b1;
                w_bus        = w_idx_word;
                w_next_state = S_RDA;
            end
            S_RDA: begin
                w_outA       = 1'b1;
                w_next_state = S_RDB;
            end
            S_RDB: begin
                w_outB       = 1'b1;
                w_next_state = S_CAPB;
            end
            S_CAPB: begin
                w_next_state = S_EXEC;
            end
            S_EXEC: begin
                w_next_state = S_WB;
            end
            S_WB: begin
                w_latchC     = 1'b1;
                w_drive      = 1'b1;
                w_bus        = r_result;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    assign w_sum = {1'b0, r_opA} + {1'b0, r_opB};

    always_comb begin
        w_alu_res   = '0;
        w_alu_carry = 1'b0;
        case (r_op)
            c_OP_ADD: begin
                w_alu_res   = w_sum[DATA_W-1:0];
                w_alu_carry = w_sum[DATA_W];
            end
            c_OP_SUB: begin
                w_alu_res   = r_opA - r_opB;
                w_alu_carry = (r_opA < r_opB);
            end
            c_OP_AND:  w_alu_res = r_opA & r_opB;
            c_OP_OR:   w_alu_res = r_opA | r_opB;
            c_OP_XOR:  w_alu_res = r_opA ^ r_opB;
            c_OP_SHL:  w_alu_res = r_opA << r_opB[c_SHW-1:0];
            c_OP_SHR:  w_alu_res = r_opA >> r_opB[c_SHW-1:0];
            c_OP_PASS: w_alu_res = r_opA;
            default:   w_alu_res = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            r_rd     <= '0;
            r_rs1    <= '0;
            r_rs2    <= '0;
            r_op     <= '0;
            r_opA    <= '0;
            r_opB    <= '0;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_carry  <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= (r_state == S_WB);
            if ((r_state == S_IDLE) && io_seq.i_start) begin
                r_rd  <= io_seq.i_rd;
                r_rs1 <= io_seq.i_rs1;
                r_rs2 <= io_seq.i_rs2;
                r_op  <= io_seq.i_op;
            end
            // Register-file read data lags its strobe by one cycle
            if (r_state == S_RDB) begin
                r_opA <= io_seq.i_bus;
            end
            if (r_state == S_CAPB) begin
                r_opB <= io_seq.i_bus;
            end
            if (r_state == S_EXEC) begin
                r_result <= w_alu_res;
                r_zero   <= (w_alu_res == '0);
                r_carry  <= w_alu_carry;
            end
        end
    end

    assign io_seq.o_bus         = w_bus;
    assign io_seq.o_bus_drive   = w_drive;
    assign io_seq.o_selectLatch = w_sel;
    assign io_seq.o_outputA     = w_outA;
    assign io_seq.o_outputB     = w_outB;
    assign io_seq.o_latchC      = w_latchC;
    assign io_seq.o_busy        = (r_state != S_IDLE);
    assign io_seq.o_done        = r_done;
    assign io_seq.o_result      = r_result;
    assign io_seq.o_zero        = r_zero;
    assign io_seq.o_carry       = r_carry;

endmodule

`default_nettype wire

// File: tb/tb_argon_regfile_sequencer.sv
// ============================================================================
// Module      : tb_argon_regfile_sequencer
// Description : Register-file environment, cycle-level reference model and
//               directed plus randomized stimulus for argon_regfile_sequencer.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_argon_regfile_sequencer;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    argon_regfile_sequencer_if #(.DATA_W(16), .IDX_W(4)) sif ();

    argon_regfile_sequencer #(.DATA_W(16), .IDX_W(4)) dut (
        .i_Clk   (clk),
        .i_Reset (rst),
        .io_seq  (sif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- register-file environment + bus mux ----------------
    logic [15:0] rf [16];
    logic [15:0] rf_data = 16'h0;
    logic [3:0]  lat_rd = 4'h0, lat_rs1 = 4'h0, lat_rs2 = 4'h0;
    logic        pl_en = 1'b0;
    logic [3:0]  pl_idx = 4'h0;
    logic [15:0] pl_val = 16'h0;

    assign sif.i_bus = sif.o_bus_drive ? sif.o_bus : rf_data;

    always @(posedge clk) begin
        if (sif.o_selectLatch) begin
            lat_rd  <= sif.o_bus[11:8];
            lat_rs2 <= sif.o_bus[7:4];
            lat_rs1 <= sif.o_bus[3:0];
        end
        rf_data <= sif.o_outputA ? rf[lat_rs1] : (sif.o_outputB ? rf[lat_rs2] : 16'h0);
        if (sif.o_latchC && lat_rd != 4'h0) rf[lat_rd] <= sif.o_bus;
        if (pl_en && pl_idx != 4'h0) rf[pl_idx] <= pl_val;
    end

    // ---------------- behavioural reference model ----------------
    // Phase counts cycles since acceptance: 1 select, 2 readA, 3 readB,
    // 4 capture B, 5 execute, 6 write-back, 0 idle.
    logic [15:0] gold [16];
    int          m_p = 0;
    logic        m_done = 1'b0;
    logic [15:0] m_res = 16'h0;
    logic        m_zero = 1'b0, m_carry = 1'b0;
    logic [16:0] m_pend = 17'h0;
    logic [3:0]  m_rd = 4'h0, m_rs1 = 4'h0, m_rs2 = 4'h0;

    function automatic logic [16:0] alu(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        int unsigned ai = a, bi = b, r = 0;
        logic c = 1'b0;
        case (op)
            3'd0: begin r = ai + bi; c = (r >= 32'h10000); end
            3'd1: begin r = ai - bi; c = (ai < bi); end
            3'd2: r = ai & bi;
            3'd3: r = ai | bi;
            3'd4: r = ai ^ bi;
            3'd5: r = ai << (bi % 16);
            3'd6: r = ai >> (bi % 16);
            default: r = ai;
        endcase
        return {c, r[15:0]};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_p <= 0; m_done <= 1'b0; m_res <= 16'h0; m_zero <= 1'b0; m_carry <= 1'b0;
        end else begin
            m_done <= (m_p == 6);
            if (pl_en && pl_idx != 4'h0) gold[pl_idx] <= pl_val;
            case (m_p)
                0: if (sif.i_start) begin
                    m_rd <= sif.i_rd; m_rs1 <= sif.i_rs1; m_rs2 <= sif.i_rs2;
                    m_pend <= alu(sif.i_op, gold[sif.i_rs1], gold[sif.i_rs2]);
                    m_p <= 1;
                end
                5: begin
                    m_res <= m_pend[15:0]; m_zero <= (m_pend[15:0] == 16'h0);
                    m_carry <= m_pend[16]; m_p <= 6;
                end
                6: begin
                    if (m_rd != 4'h0) gold[m_rd] <= m_res;
                    m_p <= 0;
                end
                default: m_p <= m_p + 1;
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare against the model ----------------
    always @(negedge clk) begin
        logic [6:0]  e_ctl, a_ctl;
        logic [15:0] e_bus;
        e_ctl = {m_p == 1, m_p == 2, m_p == 3, m_p == 6, (m_p == 1) || (m_p == 6), m_p != 0, m_done};
        a_ctl = {sif.o_selectLatch, sif.o_outputA, sif.o_outputB, sif.o_latchC,
                 sif.o_bus_drive, sif.o_busy, sif.o_done};
        e_bus = (m_p == 1) ? {4'h0, m_rd, m_rs2, m_rs1} : ((m_p == 6) ? m_res : 16'h0);
        check("ctl", 32'(a_ctl), 32'(e_ctl));
        check("bus", 32'(sif.o_bus), 32'(e_bus));
        check("res", 32'({sif.o_carry, sif.o_zero, sif.o_result}), 32'({m_carry, m_zero, m_res}));
    end

    // ---------------- stimulus helpers ----------------
    task automatic preload(input logic [3:0] idx, input logic [15:0] val);
        @(negedge clk);
        pl_en = 1'b1; pl_idx = idx; pl_val = val;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic run_op(input logic [3:0] rd, input logic [3:0] rs1, input logic [3:0] rs2,
                          input logic [2:0] op, output logic [15:0] sel_bus);
        int n;
        @(negedge clk);
        sif.i_rd = rd; sif.i_rs1 = rs1; sif.i_rs2 = rs2; sif.i_op = op; sif.i_start = 1'b1;
        @(negedge clk);
        sif.i_start = 1'b0;
        sel_bus = sif.o_bus;
        n = 0;
        while (!sif.o_done && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("latency", 32'(n), 32'd6);
    endtask

    logic [15:0] sb;

    initial begin
        rst = 1'b1;
        sif.i_start = 1'b0; sif.i_rd = 4'h0; sif.i_rs1 = 4'h0; sif.i_rs2 = 4'h0; sif.i_op = 3'd0;
        for (int i = 0; i < 16; i++) begin rf[i] = 16'h0; gold[i] = 16'h0; end
        repeat (2) @(negedge clk);
        #1;
        check("rst_busy", 32'(sif.o_busy), 32'd0);
        check("rst_drive", 32'({sif.o_bus_drive, sif.o_bus}), 32'd0);
        check("rst_result", 32'({sif.o_carry, sif.o_zero, sif.o_result}), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // ADD, select word, then read back r3
        preload(4'd1, 16'h0005); preload(4'd2, 16'h0007);
        run_op(4'd3, 4'd1, 4'd2, 3'd0, sb);
        check("t1_selbus", 32'(sb), 32'h0321);
        check("t1_add", 32'({sif.o_carry, sif.o_zero, sif.o_result}), 32'h0000C);
        run_op(4'd6, 4'd3, 4'd0, 3'd7, sb);
        check("t1_r3", 32'(sif.o_result), 32'h000C);

        // SUB borrow, ADD wrap to zero
        preload(4'd1, 16'h0003); preload(4'd2, 16'h0005);
        run_op(4'd7, 4'd1, 4'd2, 3'd1, sb);
        check("t2_sub", 32'({sif.o_carry, sif.o_zero, sif.o_result}), 32'h2FFFE);
        preload(4'd1, 16'hFFFF); preload(4'd2, 16'h0001);
        run_op(4'd7, 4'd1, 4'd2, 3'd0, sb);
        check("t2_addwrap", 32'({sif.o_carry, sif.o_zero, sif.o_result}), 32'h30000);

        // r0 source, r0 destination
        preload(4'd4, 16'h00F0);
        run_op(4'd5, 4'd0, 4'd4, 3'd3, sb);
        check("t3_or", 32'(sif.o_result), 32'h00F0);
        run_op(4'd0, 4'd5, 4'd0, 3'd7, sb);
        check("t3_pass_r0", 32'(sif.o_result), 32'h00F0);
        run_op(4'd8, 4'd0, 4'd0, 3'd7, sb);
        check("t3_r0_zero", 32'({sif.o_zero, sif.o_result}), 32'h10000);

        // Shifts use only opB[3:0]
        preload(4'd1, 16'h8001); preload(4'd2, 16'h0011);
        run_op(4'd9, 4'd1, 4'd2, 3'd5, sb);
        check("t4_shl", 32'({sif.o_carry, sif.o_result}), 32'h0002);
        run_op(4'd9, 4'd1, 4'd2, 3'd6, sb);
        check("t4_shr", 32'({sif.o_carry, sif.o_result}), 32'h4000);

        // Start pulse during RDA is ignored
        @(negedge clk);
        sif.i_rd = 4'd10; sif.i_rs1 = 4'd1; sif.i_rs2 = 4'd4; sif.i_op = 3'd4; sif.i_start = 1'b1;
        @(negedge clk); sif.i_start = 1'b0;
        @(negedge clk); sif.i_start = 1'b1;
        @(negedge clk); sif.i_start = 1'b0;
        repeat (4) @(negedge clk);
        check("t5_rda_done", 32'(sif.o_done), 32'd1);
        @(negedge clk);
        check("t5_rda_idle", 32'({sif.o_busy, sif.o_selectLatch}), 32'd0);

        // Start held high: back-to-back operations with random fields
        for (int i = 1; i < 16; i++) preload(i[3:0], 16'($urandom));
        sif.i_start = 1'b1;
        for (int c = 0; c < 70; c++) begin
            @(negedge clk);
            sif.i_rd = 4'($urandom); sif.i_rs1 = 4'($urandom);
            sif.i_rs2 = 4'($urandom); sif.i_op = 3'($urandom);
        end
        @(negedge clk); sif.i_start = 1'b0;
        repeat (8) @(negedge clk);

        // Random start pulses and fields
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            sif.i_start = ($urandom_range(0, 3) == 0);
            sif.i_rd = 4'($urandom); sif.i_rs1 = 4'($urandom);
            sif.i_rs2 = 4'($urandom); sif.i_op = 3'($urandom);
        end
        @(negedge clk); sif.i_start = 1'b0;
        repeat (8) @(negedge clk);

        // Reset during RDB aborts at once
        preload(4'd1, 16'h1234); preload(4'd2, 16'h1111);
        @(negedge clk);
        sif.i_rd = 4'd11; sif.i_rs1 = 4'd1; sif.i_rs2 = 4'd2; sif.i_op = 3'd0; sif.i_start = 1'b1;
        @(negedge clk); sif.i_start = 1'b0;
        repeat (2) @(negedge clk);
        check("t6_in_rdb", 32'(sif.o_outputB), 32'd1);
        rst = 1'b1;
        #1;
        check("t6_abort", 32'({sif.o_selectLatch, sif.o_outputA, sif.o_outputB, sif.o_latchC,
                               sif.o_bus_drive, sif.o_busy}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("t6_quiet", 32'({sif.o_busy, sif.o_bus_drive}), 32'd0);
        run_op(4'd12, 4'd1, 4'd2, 3'd0, sb);
        check("t6_add", 32'({sif.o_carry, sif.o_zero, sif.o_result}), 32'h02345);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
